// File: rtl/tm_lif_array.sv
// tm_lif_array: time-multiplexed array of leaky integrate-and-fire neurons.
// One neuron (index ptr) is updated per enabled cycle, in round-robin order.
// The update applies a shift-based leak, then saturating integration of the
// input current, then a comparison against a runtime threshold. A neuron
// that fires is silenced for its next REFRAC update slots.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - update neuron ptr this cycle and advance ptr
//   current     - input current for neuron ptr (CUR_W bits)
//   threshold   - shared firing threshold (W bits), sampled on each update
//   ptr         - neuron index for the next enabled update (registered)
//   spike       - one-hot spike pulse, one cycle after the firing update
//   frame_done  - pulse one cycle after the update of neuron N_NEURONS-1
//   rd_idx      - membrane readback select
//   rd_state    - membrane value of neuron rd_idx, one cycle latency
module tm_lif_array #(
  parameter int unsigned N_NEURONS  = 8,
  parameter int unsigned W          = 8,
  parameter int unsigned CUR_W      = 8,
  parameter int unsigned LEAK_SHIFT = 3,
  parameter int unsigned REFRAC     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [CUR_W-1:0]             current,
  input  logic [W-1:0]                 threshold,
  output logic [$clog2(N_NEURONS)-1:0] ptr,
  output logic [N_NEURONS-1:0]         spike,
  output logic                         frame_done,
  input  logic [$clog2(N_NEURONS)-1:0] rd_idx,
  output logic [W-1:0]                 rd_state
);

  localparam int unsigned PTR_W  = $clog2(N_NEURONS);
  localparam int unsigned REFR_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic [W-1:0]         r_v [N_NEURONS];
  logic [PTR_W-1:0]     r_ptr;
  logic [N_NEURONS-1:0] r_spike;
  logic                 r_frame_done;
  logic [W-1:0]         r_rd_state;

  logic [W-1:0] w_v_cur;
  logic [W-1:0] w_leaked;
  logic [W:0]   w_sum;
  logic [W-1:0] w_sat;
  logic         w_in_refr;
  logic         w_fire;
  logic         w_last;
  logic [W-1:0] w_rd_val;

  // Leak, saturating integration and threshold compare for neuron ptr.
  always_comb begin
    w_v_cur  = r_v[r_ptr];
    w_leaked = w_v_cur - (w_v_cur >> LEAK_SHIFT);
    w_sum    = {1'b0, w_leaked} + (W+1)'(current);
    w_sat    = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
    w_fire   = !w_in_refr && (w_sat >= threshold);
    w_last   = (r_ptr == PTR_W'(N_NEURONS - 1));
  end

  // Readback mux; indices past the last neuron match nothing and read 0.
  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (rd_idx == PTR_W'(k)) w_rd_val = r_v[k];
    end
  end

  // Refractory counters exist only when a refractory period is configured.
  generate
    if (REFRAC > 0) begin : g_refr
      logic [REFR_W-1:0] r_refr [N_NEURONS];

      assign w_in_refr = (r_refr[r_ptr] != '0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < N_NEURONS; k++) r_refr[k] <= '0;
        end else if (en) begin
          if (w_in_refr)   r_refr[r_ptr] <= r_refr[r_ptr] - REFR_W'(1);
          else if (w_fire) r_refr[r_ptr] <= REFR_W'(REFRAC);
        end
      end
    end else begin : g_no_refr
      assign w_in_refr = 1'b0;
    end
  endgenerate

  // Membrane state, pointer, strobes and readback register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) r_v[k] <= '0;
      r_ptr        <= '0;
      r_spike      <= '0;
      r_frame_done <= 1'b0;
      r_rd_state   <= '0;
    end else begin
      r_spike      <= '0;
      r_frame_done <= 1'b0;
      r_rd_state   <= w_rd_val;
      if (en) begin
        r_ptr        <= w_last ? '0 : r_ptr + PTR_W'(1);
        r_frame_done <= w_last;
        // A refractory neuron already holds 0, so it is left untouched.
        if (!w_in_refr) begin
          if (w_fire) begin
            r_v[r_ptr]     <= '0;
            r_spike[r_ptr] <= 1'b1;
          end else begin
            r_v[r_ptr] <= w_sat;
          end
        end
      end
    end
  end

  assign ptr        = r_ptr;
  assign spike      = r_spike;
  assign frame_done = r_frame_done;
  assign rd_state   = r_rd_state;

endmodule

// File: tb/tb_tm_lif_array.sv
// Directed testbench for tm_lif_array: a 4-neuron instance for the
// integrate/leak/fire, saturation, gating, readback and reset steps, and a
// 5-neuron instance for non-power-of-2 pointer wrap and out-of-range readback.
module tb_tm_lif_array;

  logic       clk;
  logic       rst_n;

  logic       en_a;
  logic [7:0] cur_a;
  logic [7:0] thr_a;
  logic [1:0] ptr_a;
  logic [3:0] spike_a;
  logic       fd_a;
  logic [1:0] rd_idx_a;
  logic [7:0] rd_state_a;

  logic       en_b;
  logic [7:0] cur_b;
  logic [7:0] thr_b;
  logic [2:0] ptr_b;
  logic [4:0] spike_b;
  logic       fd_b;
  logic [2:0] rd_idx_b;
  logic [7:0] rd_state_b;

  int checks;
  int failures;

  tm_lif_array #(.N_NEURONS(4), .W(8), .CUR_W(8), .LEAK_SHIFT(3), .REFRAC(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .current(cur_a), .threshold(thr_a),
    .ptr(ptr_a), .spike(spike_a), .frame_done(fd_a),
    .rd_idx(rd_idx_a), .rd_state(rd_state_a)
  );

  tm_lif_array #(.N_NEURONS(5), .W(8), .CUR_W(8), .LEAK_SHIFT(3), .REFRAC(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .current(cur_b), .threshold(thr_b),
    .ptr(ptr_b), .spike(spike_b), .frame_done(fd_b),
    .rd_idx(rd_idx_b), .rd_state(rd_state_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_a(input logic e, input logic [7:0] c);
    en_a  = e;
    cur_a = c;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_b(input logic e);
    en_b = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_v0 [6];
    logic [3:0] exp_sp [6];
    exp_v0 = '{8'd40, 8'd75, 8'd0, 8'd0, 8'd0, 8'd40};
    exp_sp = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};

    checks = 0; failures = 0;
    rst_n = 1'b0;
    en_a = 1'b0; cur_a = 8'd0; thr_a = 8'd100; rd_idx_a = 2'd0;
    en_b = 1'b0; cur_b = 8'd10; thr_b = 8'd255; rd_idx_b = 3'd1;

    // Reset state
    #3;
    chk("reset_ptr", 32'(ptr_a), 32'd0);
    chk("reset_spike", 32'(spike_a), 32'd0);
    chk("reset_frame_done", 32'(fd_a), 32'd0);
    chk("reset_rd_state", 32'(rd_state_a), 32'd0);
    #9 rst_n = 1'b1;

    // 1: integrate / leak / fire / refractory on neuron 0 (threshold 100)
    for (int f = 0; f < 6; f++) begin
      tick_a(1'b1, 8'd40);
      chk($sformatf("t1_spike_f%0d", f + 1), 32'(spike_a), 32'(exp_sp[f]));
      chk($sformatf("t1_fd_low_f%0d", f + 1), 32'(fd_a), 32'd0);
      tick_a(1'b1, 8'd0);
      // readback of v0 as registered after its update this frame
      chk($sformatf("t1_v0_f%0d", f + 1), 32'(rd_state_a), 32'(exp_v0[f]));
      tick_a(1'b1, 8'd0);
      tick_a(1'b1, 8'd0);
      chk($sformatf("t1_fd_f%0d", f + 1), 32'(fd_a), 32'd1);
      chk($sformatf("t1_ptr_wrap_f%0d", f + 1), 32'(ptr_a), 32'd0);
    end

    // 2: saturation on neuron 1 (threshold 255, current 200)
    thr_a = 8'd255; rd_idx_a = 2'd1;
    tick_a(1'b1, 8'd0);
    tick_a(1'b1, 8'd200);
    chk("t2_no_spike_200", 32'(spike_a), 32'd0);
    tick_a(1'b1, 8'd0);
    chk("t2_v1_200", 32'(rd_state_a), 32'd200);
    tick_a(1'b1, 8'd0);
    tick_a(1'b1, 8'd0);
    tick_a(1'b1, 8'd200);
    chk("t2_sat_spike", 32'(spike_a), 32'b0010);
    tick_a(1'b1, 8'd0);
    chk("t2_v1_cleared", 32'(rd_state_a), 32'd0);
    tick_a(1'b1, 8'd0);

    // 3: en gating at ptr=2
    thr_a = 8'd100;
    tick_a(1'b1, 8'd0);
    tick_a(1'b1, 8'd0);
    chk("t3_ptr_at2", 32'(ptr_a), 32'd2);
    rd_idx_a = 2'd2;
    for (int i = 0; i < 2; i++) begin
      tick_a(1'b0, 8'd50);
      chk($sformatf("t3_ptr_hold%0d", i), 32'(ptr_a), 32'd2);
      chk($sformatf("t3_spike_low%0d", i), 32'(spike_a), 32'd0);
      chk($sformatf("t3_fd_low%0d", i), 32'(fd_a), 32'd0);
      chk($sformatf("t3_v2_hold%0d", i), 32'(rd_state_a), 32'd0);
    end
    tick_a(1'b1, 8'd50);
    chk("t3_ptr_adv", 32'(ptr_a), 32'd3);
    tick_a(1'b0, 8'd0);
    chk("t3_v2_once", 32'(rd_state_a), 32'd50);
    tick_a(1'b1, 8'd0);
    chk("t3_fd", 32'(fd_a), 32'd1);

    // 6: async reset one cycle after a spike on neuron 0
    thr_a = 8'd0;
    tick_a(1'b1, 8'd0);
    chk("t6_spike0", 32'(spike_a), 32'b0001);
    thr_a = 8'd100;
    tick_a(1'b1, 8'd0);
    chk("t6_pre_ptr", 32'(ptr_a), 32'd2);
    chk("t6_pre_rd", 32'(rd_state_a), 32'd50);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_ptr", 32'(ptr_a), 32'd0);
    chk("t6_rst_spike", 32'(spike_a), 32'd0);
    chk("t6_rst_fd", 32'(fd_a), 32'd0);
    chk("t6_rst_rd", 32'(rd_state_a), 32'd0);
    #2 rst_n = 1'b1;
    rd_idx_a = 2'd0;
    tick_a(1'b1, 8'd40);
    chk("t6_post_spike", 32'(spike_a), 32'd0);
    tick_a(1'b0, 8'd0);
    chk("t6_post_v0", 32'(rd_state_a), 32'd40);

    // 4: wrap with 5 neurons
    for (int i = 0; i < 10; i++) begin
      tick_b(1'b1);
      chk($sformatf("t4_ptr%0d", i), 32'(ptr_b), 32'((i + 1) % 5));
      chk($sformatf("t4_fd%0d", i), 32'(fd_b), (i % 5 == 4) ? 32'd1 : 32'd0);
    end

    // 5: readback with 5 neurons, in and out of range
    tick_b(1'b0);
    chk("t5_rd_v1", 32'(rd_state_b), 32'd19);
    rd_idx_b = 3'd6;
    tick_b(1'b0);
    chk("t5_rd_oob", 32'(rd_state_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tm_lif_array.md
Name: tm_lif_array

Overview:
Parametrised, time-multiplexed array of leaky integrate-and-fire neurons. It is the successor of the fixed 8-neuron TM LIF block and adds the following:
- configurable neuron count and widths
- shift-based leak
- saturating integration
- runtime threshold
- refractory period
- frame-done strobe
- membrane-state readback

One neuron is updated per enabled cycle, in round-robin order. It sits between the input current scheduler and the spike router.

Parameters:
N_NEURONS, 8, number of neurons (≥2; a non-power-of-2 value is legal)
W, 8, membrane state and threshold width
CUR_W, 8, input current width (CUR_W ≤ W)
LEAK_SHIFT, 3, leak = v >> LEAK_SHIFT, applied on each update (0 = full leak to 0 before the current is added)
REFRAC, 2, number of the neuron's own update slots ignored after it spikes (0 = no refractory period)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
en  in  1  perform update for neuron ptr this cycle and advance ptr
current  in  CUR_W  input current for neuron ptr (sampled when en=1)
threshold  in  W  firing threshold, shared by all neurons, sampled on each update
ptr  out  clog2(N_NEURONS)  index of neuron updated on the next enabled cycle (registered)
spike  out  N_NEURONS  registered; bit k pulses for one cycle when neuron k fires
frame_done  out  1  one-cycle pulse after the update of neuron N_NEURONS-1
rd_idx  in  clog2(N_NEURONS)  readback select
rd_state  out  W  registered membrane value of neuron rd_idx (1-cycle latency)

Behaviour:
- Reset (async, rst_n=0): every v[k], refr[k], ptr, spike, frame_done and rd_state is cleared to 0 immediately, including in the middle of a frame or a refractory period.
- Storage: v[k] is W bits. refr[k] is clog2(REFRAC+1) bits; it exists only when REFRAC>0.
- Cycle with en=0:
  - no state change
  - ptr holds
  - spike=0, frame_done=0
- Cycle with en=1, k=ptr:
  - Refractory case, refr[k]≠0: refr[k] decrements, v[k] stays 0, current is ignored, no spike.
  - Otherwise:
    - leaked = v[k] − (v[k]>>LEAK_SHIFT)
    - sum = leaked + zero-extended current, computed in W+1 bits
    - sum saturates to 2^W−1
  - Firing case, sat_sum ≥ threshold: spike[k]=1 on the next cycle, v[k]←0, refr[k]←REFRAC.
  - Non-firing case: v[k]←sat_sum.
  - threshold=0: every non-refractory update fires.
- Latency: the update result and spike[k] are visible one clock after the enabled cycle. spike is at most one-hot; all other bits are 0 every cycle.
- ptr sequence: ptr advances k→k+1 on each en cycle and wraps N_NEURONS−1→0. frame_done pulses on the cycle after the wrapping update, concurrent with any spike from that neuron.
- Readback: rd_state reflects v[rd_idx] as registered at the previous edge. An rd_idx ≥ N_NEURONS returns 0. Reading a neuron in the same cycle it is updated returns the pre-update value.
- No combinational path exists from inputs to outputs.

Test Plan:
1. Integrate/leak/fire, with N=4, W=8, LEAK_SHIFT=3, REFRAC=2, threshold=100, en=1, current=40 for neuron 0 and 0 for the others.
   - v0 goes 40 → 75 → 106, which is ≥100, so spike[0] pulses in frame 3 and v0=0.
   - In frames 4–5, v0 stays 0 (refractory) and there is no spike.
   - In frame 6, v0=40.
2. Saturation, with threshold=255 and current=200 to neuron 1.
   - v1 goes 200, then 375, which saturates to 255 ≥255.
   - spike[1] pulses and v1 returns to 0; no wrap to 119 occurs.
3. en gating: toggle en 1,0,0,1 at ptr=2.
   - ptr holds at 2 while en=0.
   - v2 is unchanged while en=0.
   - spike and frame_done stay 0 while en=0.
   - Exactly one update of neuron 2 occurs on the en=1 cycle.
4. Wrap with N=5 (non-power-of-2):
   - ptr runs 0,1,2,3,4,0.
   - frame_done pulses once per 5 enabled cycles, aligned with the update of neuron 4.
   - ptr never reaches 5–7.
5. Readback: set rd_idx=0 after test 1 frame 2.
   - rd_state=75 one cycle later.
   - rd_idx=6 with N=5 gives rd_state=0.
6. Async reset mid-refractory: assert rst_n=0 between clock edges one cycle after spike[0].
   - All outputs and ptr are 0 immediately.
   - After release with current=40, neuron 0 integrates in its first slot: v0=40, with no refractory skip.
